// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per cycle, waits on load responses,
// aligns/extends load data and drives the register-file write port.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_wb_i,
    input  logic [4:0]  Rd_wb_i,
    input  logic        RegWrite_wb_i,
    input  logic        MemtoReg_wb_i,
    input  logic [2:0]  func3_wb_i,
    input  logic [31:0] alu_result_wb_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_wb_o,
    output logic [4:0]  Rd_wb_o,
    output logic        RegWrite_wb_o,
    output logic [31:0] Wr_reg_data_wb_o,
    output logic        err_wb_o,
    output logic [63:0] instret_wb_o
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic        pend_we_q, pend_we_d;
    logic [2:0]  pend_func3_q, pend_func3_d;
    logic [1:0]  pend_addr_q, pend_addr_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [63:0] instret_q, instret_d;

    logic        f3_legal;
    logic        misaligned;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;

    always_comb begin
        unique case (func3_wb_i)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
            default:                                f3_legal = 1'b0;
        endcase
        misaligned = ((func3_wb_i[1:0] == 2'b01) && alu_result_wb_i[0]) ||
                     ((func3_wb_i == 3'b010) && (alu_result_wb_i[1:0] != 2'b00));
    end

    // Lane selection uses the latched address; rdata is a naturally aligned word.
    always_comb begin
        unique case (pend_addr_q)
            2'd0:    byte_lane = dmem_rdata_i[7:0];
            2'd1:    byte_lane = dmem_rdata_i[15:8];
            2'd2:    byte_lane = dmem_rdata_i[23:16];
            default: byte_lane = dmem_rdata_i[31:24];
        endcase
        half_lane = pend_addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (pend_func3_q)
            3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_data = {24'd0, byte_lane};
            3'b101:  load_data = {16'd0, half_lane};
            default: load_data = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pend_rd_d    = pend_rd_q;
        pend_we_d    = pend_we_q;
        pend_func3_d = pend_func3_q;
        pend_addr_d  = pend_addr_q;
        rd_d         = rd_q;
        we_d         = 1'b0;
        data_d       = data_q;
        err_d        = 1'b0;
        instret_d    = instret_q;

        unique case (state_q)
            StIdle: begin
                if (valid_wb_i) begin
                    if (!MemtoReg_wb_i) begin
                        we_d      = RegWrite_wb_i && (Rd_wb_i != 5'd0);
                        instret_d = instret_q + 64'd1;
                        if (we_d) begin
                            rd_d   = Rd_wb_i;
                            data_d = alu_result_wb_i;
                        end
                    end else if (f3_legal && !misaligned) begin
                        state_d      = StWait;
                        pend_rd_d    = Rd_wb_i;
                        pend_we_d    = RegWrite_wb_i;
                        pend_func3_d = func3_wb_i;
                        pend_addr_d  = alu_result_wb_i[1:0];
                    end else begin
                        err_d     = 1'b1;
                        instret_d = instret_q + 64'd1;
                    end
                end
            end
            default: begin
                if (dmem_rvalid_i) begin
                    state_d   = StIdle;
                    we_d      = pend_we_q && (pend_rd_q != 5'd0);
                    instret_d = instret_q + 64'd1;
                    if (we_d) begin
                        rd_d   = pend_rd_q;
                        data_d = load_data;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pend_rd_q    <= 5'd0;
            pend_we_q    <= 1'b0;
            pend_func3_q <= 3'd0;
            pend_addr_q  <= 2'd0;
            rd_q         <= 5'd0;
            we_q         <= 1'b0;
            data_q       <= 32'd0;
            err_q        <= 1'b0;
            instret_q    <= 64'd0;
        end else begin
            state_q      <= state_d;
            pend_rd_q    <= pend_rd_d;
            pend_we_q    <= pend_we_d;
            pend_func3_q <= pend_func3_d;
            pend_addr_q  <= pend_addr_d;
            rd_q         <= rd_d;
            we_q         <= we_d;
            data_q       <= data_d;
            err_q        <= err_d;
            instret_q    <= instret_d;
        end
    end

    assign stall_wb_o       = (state_q == StWait);
    assign Rd_wb_o          = rd_q;
    assign RegWrite_wb_o    = we_q;
    assign Wr_reg_data_wb_o = data_q;
    assign err_wb_o         = err_q;
    assign instret_wb_o     = instret_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage RV32I pipeline. Accepts one retiring instruction per cycle from the MEM/WB boundary and waits for data-memory load responses. It aligns and sign/zero-extends load data, then drives the register-file write port consumed by the decode stage (destination index, write enable, write data). Also flags malformed accesses, stalls upstream while a load is outstanding, and keeps the retired-instruction counter.

## Interface
- No parameters.
- clk  input  1  pipeline clock.
- rst  input  1  reset; synchronous, active-high.
- valid_wb_i  input  1  MEM stage presents an instruction this cycle.
- Rd_wb_i  input  5  destination register index.
- RegWrite_wb_i  input  1  instruction writes a register.
- MemtoReg_wb_i  input  1  instruction is a load.
- func3_wb_i  input  3  load width/sign code.
- alu_result_wb_i  input  32  ALU result; for loads, the byte address.
- dmem_rvalid_i  input  1  load response valid.
- dmem_rdata_i  input  32  load response word (naturally aligned).
- stall_wb_o  output  1  WB busy; upstream holds its instruction.
- Rd_wb_o  output  5  register-file write index.
- RegWrite_wb_o  output  1  register-file write enable (single-cycle pulse).
- Wr_reg_data_wb_o  output  32  register-file write data.
- err_wb_o  output  1  one-cycle pulse: misaligned or illegal load retired.
- instret_wb_o  output  64  retired-instruction count.

## Operation
- States: IDLE, WAIT.
- Accept: valid_wb_i=1 in IDLE. In WAIT, valid_wb_i is ignored.
- stall_wb_o = (state==WAIT). This includes the cycle in which dmem_rvalid_i arrives.
- Non-load accept (MemtoReg=0):
  - Next cycle, RegWrite_wb_o = RegWrite_wb_i && (Rd_wb_i≠0).
  - Wr_reg_data_wb_o = alu_result_wb_i; Rd_wb_o = Rd_wb_i.
  - Stays IDLE.
- Load accept, legal and aligned: latch Rd, RegWrite, func3 and addr[1:0]; go to WAIT.
- Load legality:
  - func3 ∈ {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}. Any other value is illegal.
  - Misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]≠0. On misalignment the MEM stage issues no memory request.
- Illegal or misaligned load:
  - No WAIT.
  - Next cycle: err_wb_o=1, RegWrite_wb_o=0. The instruction still counts as retired.
- WAIT with dmem_rvalid_i=1:
  - Extract byte lane rdata[8·a+7:8·a] (a = addr[1:0]) or half lane rdata[16·a[1]+15:16·a[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Next cycle: outputs written as in the non-load case, then return to IDLE.
- Load with Rd=0 or RegWrite=0 still waits for and consumes its response; the write is suppressed.
- dmem_rvalid_i in IDLE is ignored.
- instret_wb_o increments by 1 on every retirement cycle (the cycle in which the write/err outputs are driven), whether or not a write occurs. The counter wraps modulo 2^64.
- Rd_wb_o and Wr_reg_data_wb_o hold their last values when RegWrite_wb_o=0. The decode stage must use them only while enable is high.

## Timing
- Reset (synchronous, any state, including mid-WAIT):
  - state=IDLE; the pending load is dropped and never written.
  - All outputs 0: stall, Rd, RegWrite, Wr_reg_data, err, instret.
- Latency:
  - Non-load: accept cycle N → write at N+1.
  - Load: accept N, rvalid at N+k (k≥1) → write at N+k+1.
  - stall_wb_o is high in cycles N+1 … N+k.
- Throughput: one non-load per cycle. After a load write at cycle M, the next accept occurs at M (state is already IDLE at M).
- All outputs are registered except stall_wb_o, which is decoded directly from state.

## Test plan
- ALU write: accept Rd=5, RegWrite=1, MemtoReg=0, result 0x12345678 at cycle N → at N+1: RegWrite_wb_o=1, Rd_wb_o=5, data 0x12345678, instret=1; at N+2: RegWrite_wb_o=0.
- LB sign-extend: addr 0x1003, rdata 0x80000000, rvalid 3 cycles after accept → stall high 3 cycles; data 0xFFFFFF80 one cycle after rvalid.
- LHU: addr 0x2002, rdata 0xBEEF1234 → data 0x0000BEEF. Also LW aligned: rdata 0xCAFEF00D → data 0xCAFEF00D.
- Misaligned/illegal: LW at addr 0x3002, and func3=011 → each gives no WAIT, err_wb_o pulse, RegWrite_wb_o=0, instret +1.
- Rd=0: ALU write and load to x0 → RegWrite_wb_o stays 0. The load still waits for rvalid; instret +1 each.
- Reset mid-WAIT: assert rst one cycle before rvalid → no write, stall=0, instret=0. A following rvalid in IDLE has no effect.
